// File: rtl/transmit.sv
// 8N1 UART transmitter with a one-byte holding register in front of the shifter.
// Accepts bytes on a valid/ready handshake; txd idles high and is fully registered.
module transmit #(
  parameter real BAUD = 9.6e3,
  parameter real FREQ = 12e6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       txd,
  output logic       busy
);

  localparam int CYCLES = int'(FREQ / BAUD);
  localparam int CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bitn, bitn_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    hold;
  logic          hold_full;
  logic          live;
  logic          txd_n;
  logic          take;
  logic          bit_end;
  logic          accept;

  // live keeps ready low during reset and raises it on the first released edge
  assign ready   = live & ~hold_full;
  assign busy    = (state != IDLE) | hold_full;
  assign accept  = valid & ready;
  assign bit_end = (cnt == CMAX);

  always_comb begin
    state_n = state;
    cnt_n   = bit_end ? '0 : cnt + 1'b1;
    bitn_n  = bitn;
    shreg_n = shreg;
    txd_n   = txd;
    take    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (hold_full) begin
          state_n = START;
          shreg_n = hold;
          txd_n   = 1'b0;
          take    = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          bitn_n  = 3'd0;
          txd_n   = shreg[0];
          shreg_n = {1'b0, shreg[7:1]};
        end
      end
      DATA: begin
        if (bit_end) begin
          bitn_n = bitn + 3'd1;
          if (bitn == 3'd7) begin
            state_n = STOP;
            txd_n   = 1'b1;
          end else begin
            txd_n   = shreg[0];
            shreg_n = {1'b0, shreg[7:1]};
          end
        end
      end
      STOP: begin
        // chain straight into the next start bit when a byte is waiting
        if (bit_end) begin
          if (hold_full) begin
            state_n = START;
            shreg_n = hold;
            txd_n   = 1'b0;
            take    = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bitn      <= 3'd0;
      shreg     <= 8'h00;
      txd       <= 1'b1;
      hold      <= 8'h00;
      hold_full <= 1'b0;
      live      <= 1'b0;
    end else begin
      live  <= 1'b1;
      state <= state_n;
      cnt   <= cnt_n;
      bitn  <= bitn_n;
      shreg <= shreg_n;
      txd   <= txd_n;
      if (accept) begin
        hold      <= data;
        hold_full <= 1'b1;
      end else if (take) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_transmit.sv
// Scoreboarded bench for transmit: handshaken bytes queue up as expectations,
// a behavioural UART receiver on txd decodes frames and checks them in order.
module tb_transmit;

  localparam int C = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready, txd, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int starts[$];

  transmit #(.BAUD(1e6), .FREQ(12e6)) dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid),
    .ready(ready), .txd(txd), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit keep, output int acc_c);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    acc_c = 0;
    data = b;
    valid = 1'b1;
    while (!got && n < 5000) begin
      @(negedge clk);
      got = ready;
      tick();
      n++;
    end
    if (!got) begin
      chk("send_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back(b);
      acc_c = cyc;
    end
    if (!keep) valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 1000000) begin
      tick();
      n++;
    end
    chk(name, (exp_q.size() == 0 && !busy) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // behavioural receiver: sample each bit mid-period after the falling start edge
  initial begin
    bit act;
    int m;
    logic prev;
    logic [7:0] sh;
    act = 1'b0;
    m = 0;
    prev = 1'b1;
    sh = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 1'b0;
        prev = 1'b1;
      end else if (!act) begin
        if (prev && !txd) begin
          act = 1'b1;
          m = 0;
          starts.push_back(cyc);
        end
      end else begin
        m++;
        if (m == C/2) begin
          chk("start_bit", {31'd0, txd}, 32'd0);
        end else if (m > C/2 && m < C/2 + 9*C && (m - C/2) % C == 0) begin
          sh[(m - C/2) / C - 1] = txd;
        end else if (m == C/2 + 9*C) begin
          chk("stop_bit", {31'd0, txd}, 32'd1);
          if (exp_q.size() == 0) chk("unexpected_frame", {24'd0, sh}, 32'hFFFF_FFFF);
          else chk("frame_byte", {24'd0, sh}, {24'd0, exp_q.pop_front()});
          act = 1'b0;
        end
      end
      prev = txd;
    end
  end

  initial begin
    #(2_000_000 * 10);
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, a3, n0, bad;
    logic [7:0] b;

    // reset state
    repeat (3) tick();
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", {31'd0, ready}, 32'd1);

    // idle with valid low stays quiet
    bad = 0;
    repeat (3*C) begin
      tick();
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // single byte: latency, completion timing
    n0 = starts.size();
    send(8'h55, 1'b0, a1);
    chk("accept_ready_low", {31'd0, ready}, 32'd0);
    tick();
    chk("ready_back", {31'd0, ready}, 32'd1);
    chk("txd_low_n1", {31'd0, txd}, 32'd0);
    while (cyc < a1 + 10*C) tick();
    chk("busy_end_frame", {31'd0, busy}, 32'd1);
    tick();
    chk("busy_low_after", {31'd0, busy}, 32'd0);
    chk("start_latency", (starts.size() > n0) ? starts[n0] : -1, a1 + 1);
    drain("drain_single");

    // back-to-back
    n0 = starts.size();
    send(8'hA5, 1'b1, a1);
    send(8'h3C, 1'b0, a2);
    drain("drain_b2b");
    chk("b2b_frames", starts.size() - n0, 2);
    if (starts.size() - n0 == 2) chk("b2b_gap", starts[n0+1] - starts[n0], 10*C);

    // backpressure
    send(8'h01, 1'b1, a1);
    send(8'h02, 1'b1, a2);
    chk("bp_ready_held", {31'd0, ready}, 32'd0);
    repeat (4*C) tick();
    chk("bp_ready_mid", {31'd0, ready}, 32'd0);
    send(8'h03, 1'b0, a3);
    chk("bp_acc2", a2 - a1, 2);
    chk("bp_acc3", a3 - a1, 10*C + 2);
    drain("drain_bp");

    // reset mid-frame at bit 4
    send(8'hFF, 1'b0, a1);
    while (cyc < a1 + 1 + 5*C + 2) tick();
    rst = 1'b1;
    tick();
    chk("abort_txd", {31'd0, txd}, 32'd1);
    chk("abort_ready", {31'd0, ready}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    rst = 1'b0;
    tick();
    chk("abort_ready_back", {31'd0, ready}, 32'd1);
    n0 = starts.size();
    bad = 0;
    repeat (12*C) begin
      tick();
      if (txd !== 1'b1) bad++;
    end
    chk("abort_no_frame", bad + starts.size() - n0, 0);
    send(8'h80, 1'b0, a1);
    drain("drain_after_abort");

    // loopback of random bytes with random gaps
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      send(b, 1'b0, a1);
      repeat ($urandom_range(0, 3*C)) tick();
    end
    drain("drain_random");

    repeat (2*C) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/transmit.md
TRANSMIT -- requirements
Module: transmit

Interface
REQ-001 The block SHALL have parameter BAUD, default 9.6e3, serial bit rate in bits/s.
REQ-002 The block SHALL have parameter FREQ, default 12e6, clk frequency in Hz.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port data  input  8  byte to transmit, slave stream payload.
REQ-006 The block SHALL have port valid  input  1  data qualifier from upstream master.
REQ-007 The block SHALL have port ready  output  1  block can accept a byte this cycle.
REQ-008 The block SHALL have port txd  output  1  serial line; idle high; feeds a receive rxd.
REQ-009 The block SHALL have port busy  output  1  high while a frame is on txd or a byte is held.

Function
REQ-010 The block SHALL derive the bit period CYCLES = round(FREQ/BAUD) clocks (1250 at defaults), held in a counter of width $clog2(CYCLES).
REQ-011 The block SHALL emit 8N1 frames: start bit 0, data[0] first through data[7], one stop bit 1, each exactly CYCLES clocks; frame = 10*CYCLES clocks.
REQ-012 The block SHALL implement states IDLE, START, DATA, STOP; IDLE->START on a byte available; START->DATA after CYCLES; DATA->STOP after 8th bit period (3-bit bit index wraps 7->0); STOP->START if a byte is held, else STOP->IDLE, after CYCLES.
REQ-013 The block SHALL contain one holding register plus the shift register, so one byte can be accepted while another is shifting.
REQ-014 The block SHALL transfer a byte only on a posedge where valid and ready are both high; data is sampled on that edge only.
REQ-015 ready SHALL be high exactly when the holding register is empty; ready SHALL NOT depend combinationally on valid.
REQ-016 Upstream SHALL keep data stable while valid is high and ready low; the block never drops or duplicates a handshaken byte.
REQ-017 From IDLE, a byte accepted on edge N SHALL drive txd low from edge N+1 (one-cycle latency); ready SHALL return high at edge N+1.
REQ-018 A held byte SHALL move to the shift register on the edge that ends the STOP bit, with the next start bit beginning that same edge (no idle gap between back-to-back frames).
REQ-019 Simultaneous acceptance and hold-to-shift transfer on one edge SHALL leave the new byte in the holding register and ready low.
REQ-020 txd SHALL be a registered output with no glitches at bit boundaries.
REQ-021 busy SHALL be low only in IDLE with holding register empty.
REQ-022 valid low for any duration SHALL leave txd high in IDLE indefinitely.

Reset
REQ-023 While rst is high at a posedge, the block SHALL go to IDLE, clear holding register, set txd=1, ready=0, busy=0.
REQ-024 The first posedge with rst low SHALL set ready=1.
REQ-025 rst asserted mid-frame SHALL abort the frame: txd=1 from the next edge, partial and held bytes discarded, no completion of the frame afterward.

Verification
REQ-026 Single byte: after reset, drive 0x55 with valid one cycle -> txd low edge N+1, bits 1,0,1,0,1,0,1,0 each 1250 clocks, stop high, busy low after 12500 clocks.
REQ-027 Back-to-back: offer 0xA5 then 0x3C with valid held -> second accepted during first frame, 20 contiguous bit periods, stop of 0xA5 followed immediately by start of 0x3C.
REQ-028 Backpressure: offer 0x01, 0x02, 0x03 continuously -> ready low while 0x02 held; 0x03 accepted only at end of 0x01 frame; all three delivered in order.
REQ-029 Reset mid-frame: send 0xFF, assert rst for 1 cycle at bit 4 -> txd=1 next edge, ready=1 after release, no further frame; subsequent 0x80 transmits correctly.
REQ-030 Loopback: txd wired to a receive instance with matching BAUD/FREQ, 8 random bytes with random valid gaps -> all bytes received equal, receive err stays 0.
REQ-031 Timeout: every scenario SHALL complete within 1e6 clocks, else the bench fails.
